// File: rtl/stage_issue_queue.sv
// stage_issue_queue -- in-order issue stage between decode and execute.
//
// Purpose: buffers decoded instructions in a DEPTH-entry circular queue,
// resolves register operands through BYPASS_PORTS writeback forwarding
// channels (index 0 youngest / highest priority, x0 never forwarded), stalls
// the queue head on an unresolved operand, and presents the resolved ALU
// operands in a registered issue output.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 discard queued and issued-but-unconsumed work
//   decode_*_i              offered instruction (pc, ir, cw, ra, rb, valid)
//   decode_ready_o          queue can accept (registered state only)
//   wb_addr_i/wb_data_i     per-port in-flight destination and value
//   wb_valid_i/wb_ready_i   per-port write present / value final
//   issue_cw_o, issue_alu_op1_o, issue_alu_op2_o, issue_valid_o
//                           registered issue output
//   issue_ready_i           execute consumes on valid && ready
//   issue_stall_count_o     operand-hazard stall cycles
//
// Optional feature macro: STAGE_ISSUE_STALL_COUNTER_EN enables the stall
// counter; without it issue_stall_count_o is tied to 0.

package stage_issue_queue_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regaddr_t;

  localparam logic [1:0] ALU_OP1_ZERO = 2'd0;
  localparam logic [1:0] ALU_OP1_RS1  = 2'd1;
  localparam logic [1:0] ALU_OP1_IMMU = 2'd2;

  localparam logic [2:0] ALU_OP2_ZERO = 3'd0;
  localparam logic [2:0] ALU_OP2_RS2  = 3'd1;
  localparam logic [2:0] ALU_OP2_IMMI = 3'd2;
  localparam logic [2:0] ALU_OP2_IMMS = 3'd3;
  localparam logic [2:0] ALU_OP2_PC   = 3'd4;

  typedef struct packed {
    logic       ra_used;
    logic       rb_used;
    logic [1:0] alu_op1;
    logic [2:0] alu_op2;
  } control_word_t;
endpackage

module stage_issue_queue
  import stage_issue_queue_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int BYPASS_PORTS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  word_t                   decode_pc_i,
  input  word_t                   decode_ir_i,
  input  control_word_t           decode_cw_i,
  input  word_t                   decode_ra_i,
  input  word_t                   decode_rb_i,
  input  logic                    decode_valid_i,
  output logic                    decode_ready_o,
  input  regaddr_t                wb_addr_i [BYPASS_PORTS],
  input  word_t                   wb_data_i [BYPASS_PORTS],
  input  logic [BYPASS_PORTS-1:0] wb_valid_i,
  input  logic [BYPASS_PORTS-1:0] wb_ready_i,
  output control_word_t           issue_cw_o,
  output word_t                   issue_alu_op1_o,
  output word_t                   issue_alu_op2_o,
  output logic                    issue_valid_o,
  input  logic                    issue_ready_i,
  output logic [31:0]             issue_stall_count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

  word_t         r_qPc [DEPTH];
  word_t         r_qIr [DEPTH];
  control_word_t r_qCw [DEPTH];
  word_t         r_qRa [DEPTH];
  word_t         r_qRb [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  control_word_t r_issueCw;
  word_t         r_issueOp1, r_issueOp2;
  logic          r_issueValid;

  logic          w_decodeOccurs, w_queueHasHead, w_headPresent;
  word_t         w_headPc, w_headIr, w_headRa, w_headRb;
  control_word_t w_headCw;
  regaddr_t      w_rs1, w_rs2;
  word_t         w_ra, w_rb, w_op1, w_op2;
  logic          w_raReady, w_rbReady, w_hazard;
  logic          w_issueLoad, w_push, w_pop;
  word_t         w_immI, w_immS, w_immU;
  logic          w_unusedIrBits;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on the registered count, so execute/writeback never
  // reach decode combinationally.
  assign decode_ready_o = (r_count < FULL_COUNT);
  assign w_decodeOccurs = decode_valid_i && decode_ready_o;

  // With an empty queue the incoming instruction is the head (fall-through).
  assign w_queueHasHead = (r_count != '0);
  assign w_headPresent  = w_queueHasHead || w_decodeOccurs;
  assign w_headPc = w_queueHasHead ? r_qPc[r_head] : decode_pc_i;
  assign w_headIr = w_queueHasHead ? r_qIr[r_head] : decode_ir_i;
  assign w_headCw = w_queueHasHead ? r_qCw[r_head] : decode_cw_i;
  assign w_headRa = w_queueHasHead ? r_qRa[r_head] : decode_ra_i;
  assign w_headRb = w_queueHasHead ? r_qRb[r_head] : decode_rb_i;

  assign w_rs1 = w_headIr[19:15];
  assign w_rs2 = w_headIr[24:20];
  assign w_immI = {{20{w_headIr[31]}}, w_headIr[31:20]};
  assign w_immS = {{20{w_headIr[31]}}, w_headIr[31:25], w_headIr[11:7]};
  assign w_immU = {w_headIr[31:12], 12'h000};
  assign w_unusedIrBits = ^{w_headIr[14:12], w_headIr[6:0]};

  // Scanning from the highest port down lets the lowest-index match win.
  always_comb begin
    w_ra      = w_headRa;
    w_raReady = 1'b1;
    w_rb      = w_headRb;
    w_rbReady = 1'b1;
    for (int i = BYPASS_PORTS - 1; i >= 0; i--) begin
      if (wb_valid_i[i] && (wb_addr_i[i] == w_rs1) && (w_rs1 != '0)) begin
        w_ra      = wb_data_i[i];
        w_raReady = wb_ready_i[i];
      end
      if (wb_valid_i[i] && (wb_addr_i[i] == w_rs2) && (w_rs2 != '0)) begin
        w_rb      = wb_data_i[i];
        w_rbReady = wb_ready_i[i];
      end
    end
  end

  assign w_hazard = (w_headCw.ra_used && !w_raReady) ||
                    (w_headCw.rb_used && !w_rbReady);

  always_comb begin
    w_op1 = '0;
    case (w_headCw.alu_op1)
      ALU_OP1_IMMU: w_op1 = w_immU;
      ALU_OP1_RS1:  w_op1 = w_ra;
      default:      w_op1 = '0;
    endcase
  end

  always_comb begin
    w_op2 = '0;
    case (w_headCw.alu_op2)
      ALU_OP2_IMMI: w_op2 = w_immI;
      ALU_OP2_IMMS: w_op2 = w_immS;
      ALU_OP2_PC:   w_op2 = w_headPc;
      ALU_OP2_RS2:  w_op2 = w_rb;
      default:      w_op2 = '0;
    endcase
  end

  // A fall-through instruction that issues immediately never enters storage.
  assign w_issueLoad = w_headPresent && !w_hazard && !flush_i &&
                       (!r_issueValid || issue_ready_i);
  assign w_pop  = w_issueLoad && w_queueHasHead;
  assign w_push = w_decodeOccurs && !flush_i && !(w_issueLoad && !w_queueHasHead);

  // Queue storage carries no reset; the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_qPc[r_tail] <= decode_pc_i;
      r_qIr[r_tail] <= decode_ir_i;
      r_qCw[r_tail] <= decode_cw_i;
      r_qRa[r_tail] <= decode_ra_i;
      r_qRb[r_tail] <= decode_rb_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= nextPtr(r_tail);
      if (w_pop)  r_head <= nextPtr(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue register: data only changes on a load, so it holds while stalled
  // by execute; flush drops valid but keeps the stale payload.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_issueValid <= 1'b0;
      r_issueCw    <= '0;
      r_issueOp1   <= '0;
      r_issueOp2   <= '0;
    end else if (flush_i) begin
      r_issueValid <= 1'b0;
    end else if (w_issueLoad) begin
      r_issueValid <= 1'b1;
      r_issueCw    <= w_headCw;
      r_issueOp1   <= w_op1;
      r_issueOp2   <= w_op2;
    end else if (issue_ready_i) begin
      r_issueValid <= 1'b0;
    end
  end

  assign issue_valid_o   = r_issueValid;
  assign issue_cw_o      = r_issueCw;
  assign issue_alu_op1_o = r_issueOp1;
  assign issue_alu_op2_o = r_issueOp2;

`ifdef STAGE_ISSUE_STALL_COUNTER_EN
  logic [31:0] r_stallCount;

  // Counts every cycle the head waits on an operand; survives flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stallCount <= '0;
    end else if (w_headPresent && w_hazard) begin
      r_stallCount <= r_stallCount + 32'd1;
    end
  end

  assign issue_stall_count_o = r_stallCount;
`else
  assign issue_stall_count_o = '0;
`endif

endmodule

// File: tb/tb_stage_issue_queue.sv
// tb_stage_issue_queue -- directed bench for stage_issue_queue.
//
// Purpose: drives directed decode/writeback vectors into a DEPTH=2,
// BYPASS_PORTS=4 instance, keeps a queue-based behavioural model of the
// issue stage, compares every cycle against it, and pins the model with
// hand-computed literal expectations.
//
// Ports: none (top-level bench). Honors STAGE_ISSUE_STALL_COUNTER_EN for the
// expected stall count.

module tb_stage_issue_queue;
  import stage_issue_queue_pkg::*;

  localparam int DEPTH = 2;
  localparam int P     = 4;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i;
  word_t         decode_pc_i, decode_ir_i, decode_ra_i, decode_rb_i;
  control_word_t decode_cw_i;
  logic          decode_valid_i, decode_ready_o;
  regaddr_t      wbAddr [P];
  word_t         wbData [P];
  logic [P-1:0]  wbValid, wbReady;
  control_word_t issue_cw_o;
  word_t         issue_alu_op1_o, issue_alu_op2_o;
  logic          issue_valid_o, issue_ready_i;
  logic [31:0]   issue_stall_count_o;

  always #5 clk_i = ~clk_i;

  stage_issue_queue #(.DEPTH(DEPTH), .BYPASS_PORTS(P)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .decode_pc_i(decode_pc_i), .decode_ir_i(decode_ir_i),
    .decode_cw_i(decode_cw_i), .decode_ra_i(decode_ra_i),
    .decode_rb_i(decode_rb_i), .decode_valid_i(decode_valid_i),
    .decode_ready_o(decode_ready_o),
    .wb_addr_i(wbAddr), .wb_data_i(wbData),
    .wb_valid_i(wbValid), .wb_ready_i(wbReady),
    .issue_cw_o(issue_cw_o), .issue_alu_op1_o(issue_alu_op1_o),
    .issue_alu_op2_o(issue_alu_op2_o), .issue_valid_o(issue_valid_o),
    .issue_ready_i(issue_ready_i), .issue_stall_count_o(issue_stall_count_o)
  );

  typedef struct {
    word_t         pc;
    word_t         ir;
    control_word_t cw;
    word_t         ra;
    word_t         rb;
  } instr_t;

  instr_t        mq[$];
  bit            expValid;
  control_word_t expCw;
  word_t         expOp1, expOp2;
  logic [31:0]   expStall;
  int            nVec, nMis, nAccepted;
  word_t         consumed[$];

  localparam control_word_t CW_ADDI = '{ra_used: 1'b1, rb_used: 1'b0,
                                        alu_op1: ALU_OP1_RS1, alu_op2: ALU_OP2_IMMI};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic word_t encI(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic word_t encR(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  // Operand resolution straight from the ISA/forwarding rules.
  function automatic void resolve(input instr_t in, output word_t op1, output word_t op2, output bit hz);
    word_t ir, ra, rb;
    logic [4:0] rs1, rs2;
    bit raRdy, rbRdy, f1, f2;
    ir = in.ir; rs1 = ir[19:15]; rs2 = ir[24:20];
    ra = in.ra; rb = in.rb; raRdy = 1; rbRdy = 1; f1 = 0; f2 = 0;
    for (int i = 0; i < P; i++) begin
      if (!f1 && rs1 != 0 && wbValid[i] && wbAddr[i] == rs1) begin
        ra = wbData[i]; raRdy = wbReady[i]; f1 = 1;
      end
      if (!f2 && rs2 != 0 && wbValid[i] && wbAddr[i] == rs2) begin
        rb = wbData[i]; rbRdy = wbReady[i]; f2 = 1;
      end
    end
    hz = (in.cw.ra_used && !raRdy) || (in.cw.rb_used && !rbRdy);
    case (in.cw.alu_op1)
      ALU_OP1_IMMU: op1 = {ir[31:12], 12'h000};
      ALU_OP1_RS1:  op1 = ra;
      default:      op1 = 0;
    endcase
    case (in.cw.alu_op2)
      ALU_OP2_IMMI: op2 = {{20{ir[31]}}, ir[31:20]};
      ALU_OP2_IMMS: op2 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      ALU_OP2_PC:   op2 = in.pc;
      ALU_OP2_RS2:  op2 = rb;
      default:      op2 = 0;
    endcase
  endfunction

  // Next-state of the model from the inputs presented this cycle.
  function automatic void modelStep();
    instr_t cand[$];
    instr_t nd;
    word_t o1, o2;
    bit hz, load;
    if (rst_i) begin
      mq.delete(); expValid = 0; expCw = '0; expOp1 = 0; expOp2 = 0; expStall = 0;
      return;
    end
    cand = mq;
    if (decode_valid_i && (mq.size() < DEPTH)) begin
      nd = '{pc: decode_pc_i, ir: decode_ir_i, cw: decode_cw_i, ra: decode_ra_i, rb: decode_rb_i};
      cand.push_back(nd);
    end
    load = 0; o1 = 0; o2 = 0; hz = 0;
    if (cand.size() > 0) begin
      resolve(cand[0], o1, o2, hz);
`ifdef STAGE_ISSUE_STALL_COUNTER_EN
      if (hz) expStall = expStall + 1;
`endif
      load = !hz && (!expValid || issue_ready_i) && !flush_i;
    end
    if (flush_i) begin
      mq.delete(); expValid = 0;
    end else begin
      mq = cand;
      if (load) begin
        expCw = mq[0].cw; expOp1 = o1; expOp2 = o2; expValid = 1;
        void'(mq.pop_front());
      end else if (issue_ready_i) begin
        expValid = 0;
      end
    end
  endfunction

  task automatic checkOutput();
    chk("decode_ready", 32'(decode_ready_o), 32'(mq.size() < DEPTH));
    chk("issue_valid", 32'(issue_valid_o), 32'(expValid));
    if (expValid) begin
      chk("issue_cw", 32'(issue_cw_o), 32'(expCw));
      chk("issue_op1", issue_alu_op1_o, expOp1);
      chk("issue_op2", issue_alu_op2_o, expOp2);
    end
    chk("stall_count", issue_stall_count_o, expStall);
  endtask

  task automatic stepCycle();
    if (issue_valid_o === 1'b1 && issue_ready_i) consumed.push_back(issue_alu_op2_o);
    if (decode_valid_i && decode_ready_o === 1'b1) nAccepted++;
    modelStep();
    @(posedge clk_i);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit v, input word_t ir, input control_word_t cw,
                               input word_t ra, input word_t rb);
    decode_valid_i = v;
    decode_pc_i    = 32'h1000 + {ir[11:7], 2'b00};
    decode_ir_i    = ir;
    decode_cw_i    = cw;
    decode_ra_i    = ra;
    decode_rb_i    = rb;
  endtask

  task automatic clearWb();
    for (int i = 0; i < P; i++) begin
      wbAddr[i] = '0; wbData[i] = '0;
    end
    wbValid = '0; wbReady = '0;
  endtask

  task automatic idle();
    applyStimulus(0, 32'h0, '0, 0, 0);
  endtask

  initial begin
    word_t expDrain[3];
    control_word_t cwByp, cwStall;
    expDrain = '{32'd10, 32'd11, 32'd12};
    cwByp   = '{ra_used: 1'b1, rb_used: 1'b1, alu_op1: ALU_OP1_RS1, alu_op2: ALU_OP2_RS2};
    cwStall = '{ra_used: 1'b0, rb_used: 1'b1, alu_op1: ALU_OP1_ZERO, alu_op2: ALU_OP2_RS2};
    nVec = 0; nMis = 0; nAccepted = 0;
    rst_i = 1; flush_i = 0; issue_ready_i = 1;
    clearWb(); idle();
    expValid = 0; expCw = '0; expOp1 = 0; expOp2 = 0; expStall = 0;

    // Reset state
    stepCycle(); stepCycle();
    rst_i = 0;
    chk("rst_ready", 32'(decode_ready_o), 1);
    chk("rst_valid", 32'(issue_valid_o), 0);
    chk("rst_op2", issue_alu_op2_o, 0);

    // Three back-to-back ADDIs with execute ready
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, encI(12'(5 + k), 5'd0, 5'd1), CW_ADDI, 0, 0);
      stepCycle();
      chk("addi_valid", 32'(issue_valid_o), 1);
      chk("addi_op2", issue_alu_op2_o, 32'(5 + k));
      chk("addi_ready", 32'(decode_ready_o), 1);
    end
    idle(); stepCycle();

    // Back-pressure: four offers, three fit, then drain in order
    $display("[TB] backpressure");
    issue_ready_i = 0; nAccepted = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, encI(12'(10 + k), 5'd0, 5'd2), CW_ADDI, 0, 0);
      stepCycle();
    end
    chk("full_ready", 32'(decode_ready_o), 0);
    chk("accepted", 32'(nAccepted), 3);
    idle(); issue_ready_i = 1; consumed.delete();
    for (int k = 0; k < 5; k++) stepCycle();
    chk("drain_count", 32'(consumed.size()), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("drain%0d", i), (i < consumed.size()) ? consumed[i] : 32'hDEADBEEF, expDrain[i]);

    // Bypass priority and x0 suppression
    wbAddr[0] = 5'd3; wbData[0] = 32'hAA; wbValid[0] = 1; wbReady[0] = 1;
    wbAddr[1] = 5'd0; wbData[1] = 32'hCC; wbValid[1] = 1; wbReady[1] = 0;
    wbAddr[2] = 5'd3; wbData[2] = 32'hBB; wbValid[2] = 1; wbReady[2] = 1;
    applyStimulus(1, encR(5'd0, 5'd3, 5'd4), cwByp, 32'h12345678, 0);
    stepCycle();
    chk("byp_valid", 32'(issue_valid_o), 1);
    chk("byp_op1", issue_alu_op1_o, 32'hAA);
    chk("byp_op2_x0", issue_alu_op2_o, 32'h0);
    idle(); stepCycle(); clearWb();

    // Operand hazard on rs2 for four cycles
    wbAddr[1] = 5'd7; wbData[1] = 32'h77; wbValid[1] = 1; wbReady[1] = 0;
    applyStimulus(1, encR(5'd7, 5'd2, 5'd1), cwStall, 32'h22, 32'h99);
    stepCycle();
    idle();
    for (int k = 0; k < 3; k++) stepCycle();
    chk("stall_noissue", 32'(issue_valid_o), 0);
    wbReady[1] = 1;
    stepCycle();
    chk("stall_issue", 32'(issue_valid_o), 1);
    chk("stall_op2", issue_alu_op2_o, 32'h77);
`ifdef STAGE_ISSUE_STALL_COUNTER_EN
    chk("stall_cnt", issue_stall_count_o, 4);
`else
    chk("stall_cnt", issue_stall_count_o, 0);
`endif
    stepCycle(); clearWb();

    // Flush with a queued entry, a held output and a same-cycle accept
    issue_ready_i = 0;
    applyStimulus(1, encI(12'd20, 5'd0, 5'd3), CW_ADDI, 0, 0); stepCycle();
    applyStimulus(1, encI(12'd21, 5'd0, 5'd3), CW_ADDI, 0, 0); stepCycle();
    flush_i = 1;
    applyStimulus(1, encI(12'd23, 5'd0, 5'd3), CW_ADDI, 0, 0); stepCycle();
    flush_i = 0;
    chk("flush_valid", 32'(issue_valid_o), 0);
    chk("flush_ready", 32'(decode_ready_o), 1);
    idle(); issue_ready_i = 1; consumed.delete();
    for (int k = 0; k < 3; k++) stepCycle();
    chk("flush_no_old", 32'(consumed.size()), 0);
    applyStimulus(1, encI(12'd30, 5'd0, 5'd3), CW_ADDI, 0, 0); stepCycle();
    chk("post_flush_op2", issue_alu_op2_o, 32'd30);
    idle(); stepCycle();

    // Reset in the middle of a stall with a full queue
    issue_ready_i = 0;
    wbAddr[1] = 5'd7; wbData[1] = 32'h55; wbValid[1] = 1; wbReady[1] = 0;
    applyStimulus(1, encR(5'd7, 5'd2, 5'd1), cwStall, 0, 0); stepCycle();
    applyStimulus(1, encI(12'd50, 5'd0, 5'd1), CW_ADDI, 0, 0); stepCycle();
    applyStimulus(1, encI(12'd51, 5'd0, 5'd1), CW_ADDI, 0, 0); stepCycle();
    chk("pre_rst_full", 32'(decode_ready_o), 0);
    rst_i = 1; stepCycle(); rst_i = 0;
    chk("rst2_valid", 32'(issue_valid_o), 0);
    chk("rst2_ready", 32'(decode_ready_o), 1);
    chk("rst2_cw", 32'(issue_cw_o), 0);
    chk("rst2_op1", issue_alu_op1_o, 0);
    chk("rst2_op2", issue_alu_op2_o, 0);
    chk("rst2_stall", issue_stall_count_o, 0);
    clearWb(); issue_ready_i = 1;
    applyStimulus(1, encI(12'd40, 5'd0, 5'd1), CW_ADDI, 0, 0); stepCycle();
    chk("post_rst_valid", 32'(issue_valid_o), 1);
    chk("post_rst_op2", issue_alu_op2_o, 32'd40);
    idle(); stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
